// File: rtl/lsu_pkg.sv
// Shared constants for the load/store memory stage: funct3 codes, FSM states,
// fault causes and the default request timeout.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_ILLEGAL  = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_cause_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
// Handshake: master raises mem_req with stable we/addr/wstrb/wdata and holds them
// until the slave returns mem_ack for one cycle; mem_rdata is valid only with mem_ack.
interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes, load lane select with
// extension, and the illegal-funct3 / misalignment checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] byte_shift;

  assign byte_shift = rdata_i >> {addr_lo_i, 3'b000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      2'b01: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = 4'b0011 << addr_lo_i;
      end
      2'b10: begin
        wdata_o = store_data_i;
        wstrb_o = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data_o = 32'h0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data_o = rdata_i;
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: ;
    endcase
  end

  // Stores only allow B/H/W; loads additionally allow the unsigned B/H forms.
  assign illegal_o = is_store_i ? (funct3_i[2] || (funct3_i == 3'b011))
                                : ((funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                                   (funct3_i == 3'b111));

  assign misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one data-memory transaction per start, with busy
// stall, one-cycle done pulse, fault reporting and request timeout.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [31:0]      addr,
  input  logic [31:0]      store_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      load_data,
  output logic             fault,
  output logic [1:0]       fault_cause,
  lsu_mem_if.master        mem,
  output lsu_state_e       dbg_state_o
);

  lsu_state_e   state_q;
  logic [7:0]   cnt_q;
  logic         is_store_q;
  logic [2:0]   funct3_q;
  logic [1:0]   addr_lo_q;
  logic         busy_q, done_q, fault_q;
  fault_cause_e cause_q;
  logic [31:0]  load_data_q;
  logic         mem_req_q, mem_we_q;
  logic [31:0]  mem_addr_q, mem_wdata_q;
  logic [3:0]   mem_wstrb_q;

  logic         al_is_store;
  logic [2:0]   al_funct3;
  logic [1:0]   al_addr_lo;
  logic [3:0]   al_wstrb;
  logic [31:0]  al_wdata, al_load;
  logic         al_misaligned, al_illegal;

  // In IDLE the checks look at the incoming instruction; in REQ the latched
  // copy drives load extraction so live inputs may change freely.
  assign al_is_store = (state_q == S_IDLE) ? is_store   : is_store_q;
  assign al_funct3   = (state_q == S_IDLE) ? funct3     : funct3_q;
  assign al_addr_lo  = (state_q == S_IDLE) ? addr[1:0]  : addr_lo_q;

  lsu_align u_align (
    .is_store_i   (al_is_store),
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_addr_lo),
    .store_data_i (store_data),
    .rdata_i      (mem.mem_rdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      cause_q     <= FC_NONE;
      load_data_q <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (al_illegal) begin
              fault_q <= 1'b1;
              cause_q <= FC_ILLEGAL;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (al_misaligned) begin
              fault_q <= 1'b1;
              cause_q <= FC_MISALIGN;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              is_store_q  <= is_store;
              funct3_q    <= funct3;
              addr_lo_q   <= addr[1:0];
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_we_q    <= is_store;
              mem_wstrb_q <= is_store ? al_wstrb : 4'b0000;
              mem_wdata_q <= is_store ? al_wdata : 32'h0;
              mem_req_q   <= 1'b1;
              cnt_q       <= 8'd0;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_ack) begin
            if (!is_store_q) load_data_q <= al_load;
            fault_q   <= 1'b0;
            cause_q   <= FC_NONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            fault_q   <= 1'b1;
            cause_q   <= FC_TIMEOUT;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign load_data     = load_data_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed plus randomized bench for lsu_mem_stage against a behavioural
// model of lane steering, extension, fault rules and timing.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;
  lsu_state_e  dbg_state;

  lsu_mem_if mem_if ();

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ld_model = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .load_data   (load_data),
    .fault       (fault),
    .fault_cause (fault_cause),
    .mem         (mem_if),
    .dbg_state_o (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fault rules from the ISA view: legality first, then natural alignment.
  function automatic logic [1:0] ref_cause(input bit st, input logic [2:0] f3, input logic [1:0] lo);
    int f = int'(f3);
    int l = int'(lo);
    int size;
    bit legal;
    legal = st ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
    if (!legal) return 2'b10;
    size = (f == 2) ? 4 : ((f == 1 || f == 5) ? 2 : 1);
    if ((l % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
    int l = int'(lo);
    int v;
    case (int'(f3))
      0, 4: begin
        v = int'((rd >> (8 * l)) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = int'((rd >> (16 * (l / 2))) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = int'(rd);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return (sd & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] ref_wstrb(input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'd0) return 32'd1 << int'(lo);
    if (f3 == 3'd1) return 32'd3 << int'(lo);
    return 32'hF;
  endfunction

  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int delay,
                         input string tag);
    logic [1:0]  cause;
    logic [31:0] exp_addr;
    cause    = ref_cause(st, f3, a[1:0]);
    exp_addr = a & ~32'h3;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    step();
    start = 1'b0; addr = $urandom; store_data = $urandom;
    if (cause != 2'b00) begin
      check({tag, "/f_done"}, done, 1);
      check({tag, "/f_fault"}, fault, 1);
      check({tag, "/f_cause"}, fault_cause, cause);
      check({tag, "/f_req"}, mem_if.mem_req, 0);
      check({tag, "/f_busy"}, busy, 1);
      check({tag, "/f_ld"}, load_data, ld_model);
    end else begin
      check({tag, "/req"}, mem_if.mem_req, 1);
      check({tag, "/addr"}, mem_if.mem_addr, exp_addr);
      check({tag, "/we"}, mem_if.mem_we, st);
      check({tag, "/wstrb"}, mem_if.mem_wstrb, st ? ref_wstrb(f3, a[1:0]) : 32'h0);
      if (st) check({tag, "/wdata"}, mem_if.mem_wdata, ref_wdata(f3, sd));
      check({tag, "/busy"}, busy, 1);
      check({tag, "/no_done"}, done, 0);
      for (int i = 0; i < delay; i++) begin
        step();
        check({tag, "/hold_req"}, mem_if.mem_req, 1);
        check({tag, "/hold_addr"}, mem_if.mem_addr, exp_addr);
        if (st) check({tag, "/hold_wdata"}, mem_if.mem_wdata, ref_wdata(f3, sd));
        check({tag, "/hold_done"}, done, 0);
      end
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rd;
      step();
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = $urandom;
      if (!st) ld_model = ref_load(f3, a[1:0], rd);
      check({tag, "/done"}, done, 1);
      check({tag, "/fault"}, fault, 0);
      check({tag, "/cause"}, fault_cause, 0);
      check({tag, "/req_drop"}, mem_if.mem_req, 0);
      check({tag, "/ld"}, load_data, ld_model);
    end
    step();
    check({tag, "/done_pulse"}, done, 0);
    check({tag, "/idle_busy"}, busy, 0);
  endtask

  initial begin
    int   req_cycles;
    bit   seen;
    logic [2:0] f3;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 32'h0;

    // Reset state
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ld", load_data, 0);
    check("rst_fault", fault, 0);
    check("rst_cause", fault_cause, 0);
    check("rst_req", mem_if.mem_req, 0);
    check("rst_we", mem_if.mem_we, 0);
    check("rst_addr", mem_if.mem_addr, 0);
    check("rst_wstrb", mem_if.mem_wstrb, 0);
    check("rst_wdata", mem_if.mem_wdata, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    step();

    // Directed cases
    run_txn(0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
    check("lw_const", load_data, 32'hDEADBEEF);
    run_txn(0, F3_B, 32'h103, 32'h0, 32'h80FF1234, 0, "lb");
    check("lb_const", load_data, 32'hFFFFFF80);
    run_txn(0, F3_BU, 32'h103, 32'h0, 32'h80FF1234, 1, "lbu");
    check("lbu_const", load_data, 32'h00000080);
    run_txn(1, F3_H, 32'h0A, 32'h0000ABCD, 32'h0, 3, "sh");
    check("sh_ld_kept", load_data, 32'h00000080);
    run_txn(0, F3_W, 32'h102, 32'h0, 32'h0, 0, "lw_mis");
    run_txn(1, 3'b011, 32'h102, 32'h0, 32'h0, 0, "st_ill");
    run_txn(0, F3_HU, 32'h202, 32'h0, 32'h8001_7FFE, 2, "lhu");
    run_txn(0, F3_H, 32'h202, 32'h0, 32'h8001_7FFE, 0, "lh");
    run_txn(0, F3_W, 32'h40, 32'h0, 32'h1234_5678, TO - 1, "ack_at_limit");

    // Timeout with a second start attempted while busy
    start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h200;
    step();
    req_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (mem_if.mem_req) req_cycles++;
        start = 1'b1; funct3 = 3'($urandom_range(0, 7)); addr = $urandom;
        step();
      end
    end
    start = 1'b0;
    check("to_seen", seen, 1);
    check("to_req_cycles", req_cycles, TO);
    check("to_fault", fault, 1);
    check("to_cause", fault_cause, 2'b11);
    check("to_ld", load_data, ld_model);
    step();
    check("to_busy", busy, 0);
    check("to_done", done, 0);
    step();
    check("to_no_restart", mem_if.mem_req, 0);

    // Reset in the second REQ cycle
    start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h300;
    step();
    start = 1'b0;
    step();
    check("mr_req", mem_if.mem_req, 1);
    rst_n = 1'b0;
    step();
    ld_model = 32'h0;
    check("mr_req_drop", mem_if.mem_req, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_state", dbg_state, S_IDLE);
    check("mr_ld", load_data, ld_model);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_quiet_done", done, 0);
    end
    run_txn(0, F3_W, 32'h304, 32'h0, 32'hCAFE_F00D, 1, "post_rst_lw");

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      run_txn(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
